// File: rtl/tick_meter_pkg.sv
// Shared definitions for tick_period_meter: state encoding and lock-compare tolerance.
// Build option: define TICK_METER_TOLERANCE_EN to let periods differing by 1 count as a lock match.
package tick_meter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_OVER  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    COUNT = ST_COUNT,
    OVER  = ST_OVER
  } state_e;

`ifdef TICK_METER_TOLERANCE_EN
  localparam int unsigned LOCK_TOL = 1;
`else
  localparam int unsigned LOCK_TOL = 0;
`endif

endpackage

// File: rtl/rise_detect.sv
// One-register rising-edge detector.
// Ports: inClk (clock), reset (sync, active-high), sig (input level),
//        rise_c (combinational: sig high and previous sample low).
// RESET_VAL sets the previous-sample value after reset; 1 suppresses an edge
// for a level already high at reset release.
module rise_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic inClk,
  input  logic reset,
  input  logic sig,
  output logic rise_c
);

  logic prev;

  always_ff @(posedge inClk) begin
    if (reset) prev <= RESET_VAL;
    else       prev <= sig;
  end

  assign rise_c = sig & ~prev;

endmodule

// File: rtl/tick_period_meter.sv
// Measures inClk cycles between rising edges of tickIn, reports each period,
// flags lock after LOCK_COUNT consecutive matching periods, and flags overflow
// when the count saturates without a tick.
// Ports: inClk, reset (sync, active-high), tickIn (strobe from an inClk register),
//        period [WIDTH-1:0], periodValid (1-cycle pulse), locked, overflow (sticky until next tick).
// Build option: TICK_METER_TOLERANCE_EN widens the lock match to +/-1.
module tick_period_meter
  import tick_meter_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic             inClk,
  input  logic             reset,
  input  logic             tickIn,
  output logic [WIDTH-1:0] period,
  output logic             periodValid,
  output logic             locked,
  output logic             overflow
);

  localparam int unsigned    MW         = $clog2(LOCK_COUNT);
  localparam logic [MW-1:0]  MATCH_LOCK = MW'(LOCK_COUNT - 1);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;

  state_e           state, state_d;
  logic [WIDTH-1:0] cnt, cnt_d;
  logic [WIDTH-1:0] period_d;
  logic             valid_d, locked_d, overflow_d;
  logic [MW-1:0]    match, match_d;
  logic             tick_c;
  logic [WIDTH-1:0] diff_c;
  logic             same_c;

  // Previous sample resets high so a level held through reset is not a tick.
  rise_detect #(.RESET_VAL(1'b1)) u_rise (
    .inClk (inClk),
    .reset (reset),
    .sig   (tickIn),
    .rise_c(tick_c)
  );

  // Distance between the period now ending and the last reported one.
  assign diff_c = (cnt >= period) ? (cnt - period) : (period - cnt);
  assign same_c = (diff_c <= WIDTH'(LOCK_TOL));

  // State and output registers.
  always_ff @(posedge inClk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      period      <= '0;
      periodValid <= 1'b0;
      locked      <= 1'b0;
      overflow    <= 1'b0;
      match       <= '0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      period      <= period_d;
      periodValid <= valid_d;
      locked      <= locked_d;
      overflow    <= overflow_d;
      match       <= match_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    period_d   = period;
    valid_d    = 1'b0;
    locked_d   = locked;
    overflow_d = overflow;
    match_d    = match;
    case (state)
      IDLE: begin
        if (tick_c) begin
          state_d = COUNT;
          cnt_d   = WIDTH'(1);
        end
      end
      COUNT: begin
        // A tick in the saturation cycle still reports CNT_MAX.
        if (tick_c) begin
          cnt_d    = WIDTH'(1);
          period_d = cnt;
          valid_d  = 1'b1;
          if (same_c) begin
            if (match != MATCH_LOCK) match_d = match + MW'(1);
          end else begin
            match_d = '0;
          end
          locked_d = (match_d == MATCH_LOCK);
        end else if (cnt == CNT_MAX) begin
          state_d    = OVER;
          overflow_d = 1'b1;
          locked_d   = 1'b0;
        end else begin
          cnt_d = cnt + WIDTH'(1);
        end
      end
      OVER: begin
        if (tick_c) begin
          state_d    = COUNT;
          cnt_d      = WIDTH'(1);
          overflow_d = 1'b0;
          match_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tick_period_meter.sv
// Testbench for tick_period_meter: a WIDTH=8/LOCK_COUNT=4 and a WIDTH=4/LOCK_COUNT=3
// instance share clock and reset; a timestamp-based reference model predicts every output.
module tb_tick_period_meter;

`ifdef TICK_METER_TOLERANCE_EN
  localparam int TOL = 1;
`else
  localparam int TOL = 0;
`endif

  logic       inClk = 1'b0;
  logic       reset = 1'b1;
  logic       tick8 = 1'b0;
  logic       tick4 = 1'b0;
  logic [7:0] period8;
  logic [3:0] period4;
  logic       valid8, valid4, locked8, locked4, ovf8, ovf4;

  int checks   = 0;
  int failures = 0;

  always #5 inClk = ~inClk;

  tick_period_meter #(.WIDTH(8), .LOCK_COUNT(4)) dut8 (
    .inClk(inClk), .reset(reset), .tickIn(tick8),
    .period(period8), .periodValid(valid8), .locked(locked8), .overflow(ovf8)
  );

  tick_period_meter #(.WIDTH(4), .LOCK_COUNT(3)) dut4 (
    .inClk(inClk), .reset(reset), .tickIn(tick4),
    .period(period4), .periodValid(valid4), .locked(locked4), .overflow(ovf4)
  );

  // Reference model state, index 0 = dut8, 1 = dut4.
  int   m_max [2] = '{255, 15};
  int   m_lc  [2] = '{4, 3};
  logic m_prev[2];
  bit   armed [2];
  bit   over  [2];
  int   last  [2];
  int   hist  [2][8];
  int   hcnt  [2];
  int   e_period[2];
  logic e_valid [2];
  logic e_locked[2];
  logic e_over  [2];
  int   cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // Locked when the newest LOCK_COUNT reported periods are pairwise adjacent-equal.
  function automatic bit window_locked(input int i);
    if (hcnt[i] < m_lc[i]) return 1'b0;
    for (int k = 0; k < m_lc[i] - 1; k++) begin
      int d;
      d = hist[i][k] - hist[i][k+1];
      if (d < 0) d = -d;
      if (d > TOL) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_step(input int i, input logic t, input logic r);
    bit tick;
    if (r) begin
      m_prev[i] = 1'b1; armed[i] = 0; over[i] = 0; hcnt[i] = 0;
      e_period[i] = 0; e_valid[i] = 0; e_locked[i] = 0; e_over[i] = 0;
      return;
    end
    tick = t && !m_prev[i];
    m_prev[i] = t;
    e_valid[i] = 1'b0;
    if (tick) begin
      if (armed[i] && !over[i]) begin
        e_period[i] = cyc - last[i];
        e_valid[i] = 1'b1;
        for (int k = 7; k > 0; k--) hist[i][k] = hist[i][k-1];
        hist[i][0] = e_period[i];
        if (hcnt[i] < 8) hcnt[i]++;
        e_locked[i] = window_locked(i);
      end else if (over[i]) begin
        // Only the pre-overflow period survives as a comparison reference.
        over[i] = 0; e_over[i] = 1'b0;
        if (hcnt[i] > 1) hcnt[i] = 1;
      end
      armed[i] = 1; last[i] = cyc;
    end else if (armed[i] && !over[i] && (cyc - last[i]) == m_max[i]) begin
      over[i] = 1; e_over[i] = 1'b1; e_locked[i] = 1'b0;
    end
  endtask

  task automatic cycle(input logic t8, input logic t4, input logic r);
    tick8 = t8; tick4 = t4; reset = r;
    @(posedge inClk);
    model_step(0, t8, r);
    model_step(1, t4, r);
    cyc++;
    #1;
    check("period8", 32'(period8), 32'(e_period[0]));
    check("valid8",  32'(valid8),  32'(e_valid[0]));
    check("locked8", 32'(locked8), 32'(e_locked[0]));
    check("ovf8",    32'(ovf8),    32'(e_over[0]));
    check("period4", 32'(period4), 32'(e_period[1]));
    check("valid4",  32'(valid4),  32'(e_valid[1]));
    check("locked4", 32'(locked4), 32'(e_locked[1]));
    check("ovf4",    32'(ovf4),    32'(e_over[1]));
  endtask

  // n groups of (per-hi) low cycles then hi high cycles on one instance.
  task automatic ticks(input int which, input int per, input int n, input int hi);
    for (int g = 0; g < n; g++) begin
      for (int c = 0; c < per - hi; c++) cycle(1'b0, 1'b0, 1'b0);
      for (int c = 0; c < hi; c++) cycle(which == 0, which == 1, 1'b0);
    end
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int which, per, n, hi;

    // Reset state.
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    check("rst_period8", 32'(period8), 32'd0);
    check("rst_locked8", 32'(locked8), 32'd0);
    check("rst_ovf4",    32'(ovf4),    32'd0);

    // Period 4 train: lock after the 4th reported period.
    ticks(0, 5, 1, 1);
    ticks(0, 4, 4, 1);
    check("p4_period", 32'(period8), 32'd4);
    check("p4_locked", 32'(locked8), 32'd1);
    // One period of 5: drops lock only in the exact-match build.
    ticks(0, 5, 1, 1);
    check("p5_period", 32'(period8), 32'd5);
    check("p5_valid",  32'(valid8),  32'd1);
    check("p5_locked", 32'(locked8), (TOL == 0) ? 32'd0 : 32'd1);
    ticks(0, 5, 4, 1);
    check("p5_relock", 32'(locked8), 32'd1);

    // tickIn high through reset release: no spurious tick.
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    check("held_novalid", 32'(valid8), 32'd0);
    ticks(0, 6, 1, 1);
    check("held_period", 32'(period8), 32'd6);

    // WIDTH=4 overflow and recovery.
    ticks(1, 3, 1, 1);
    idle(14);
    check("ovf_before", 32'(ovf4), 32'd0);
    idle(1);
    check("ovf_set", 32'(ovf4), 32'd1);
    ticks(1, 3, 1, 1);
    check("ovf_clear", 32'(ovf4), 32'd0);
    check("ovf_novalid", 32'(valid4), 32'd0);
    ticks(1, 6, 1, 1);
    check("after_ovf_period", 32'(period4), 32'd6);
    // Tick in the saturation cycle reports 15 without overflow.
    ticks(1, 15, 1, 1);
    check("sat_period", 32'(period4), 32'd15);
    check("sat_ovf",    32'(ovf4),    32'd0);

    // Reset mid-count while locked.
    ticks(0, 7, 5, 1);
    check("pre_rst_locked", 32'(locked8), 32'd1);
    idle(3);
    cycle(1'b0, 1'b0, 1'b1);
    check("mid_rst_locked", 32'(locked8), 32'd0);
    check("mid_rst_period", 32'(period8), 32'd0);
    ticks(0, 4, 1, 1);
    check("post_rst_first", 32'(valid8), 32'd0);
    ticks(0, 7, 1, 1);
    check("post_rst_period", 32'(period8), 32'd7);

    // WIDTH=8 overflow.
    idle(260);
    check("ovf8_set", 32'(ovf8), 32'd1);

    // Randomized periodic bursts on either instance, occasional reset.
    for (int it = 0; it < 60; it++) begin
      which = int'($urandom_range(0, 1));
      per   = int'($urandom_range(2, 19));
      n     = int'($urandom_range(1, 6));
      hi    = int'($urandom_range(1, per - 1));
      ticks(which, per, n, hi);
      if ($urandom_range(0, 19) == 0) cycle(1'b0, 1'b0, 1'b1);
    end

    // Random noise on both inputs.
    for (int c = 0; c < 300; c++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
